// File: rtl/packet_scheduler.sv
// HDMI data-island packet scheduler.
// Orders the per-frame packets (ACR, Audio InfoFrame, optional AVI InfoFrame)
// and then serves audio sample packets out of a small sample FIFO. Each
// packet_enable request from the HDMI core selects exactly one packet type,
// registered on the requesting clk_pixel edge and held until the next request.
module packet_scheduler #(
   parameter int AUDIO_BIT_WIDTH = 16,
   parameter int CHANNELS        = 2,
   parameter int FIFO_DEPTH      = 8,
   parameter int SEND_AVI        = 1
) (
   input  logic                                clk_pixel,
   input  logic                                rst_n,
   input  logic                                frame_start,
   input  logic                                packet_enable,
   input  logic                                sample_valid,
   input  logic [CHANNELS*AUDIO_BIT_WIDTH-1:0] sample_in,
   output logic                                sample_ready,
   output logic [7:0]                          packet_type,
   output logic [CHANNELS*AUDIO_BIT_WIDTH-1:0] audio_sample_word,
   output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
   output logic                                overflow
);

   localparam int DATA_W  = CHANNELS * AUDIO_BIT_WIDTH;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int LEVEL_W = PTR_W + 1;

   localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(FIFO_DEPTH);

   // Packet type codes presented to the HDMI core.
   localparam logic [7:0] PT_NULL  = 8'h00;
   localparam logic [7:0] PT_ACR   = 8'h01;
   localparam logic [7:0] PT_AUDIO = 8'h02;
   localparam logic [7:0] PT_AVI   = 8'h82;
   localparam logic [7:0] PT_AIF   = 8'h84;

   typedef enum logic [1:0] {
      S_ACR,
      S_AIF,
      S_AVI,
      S_AUDIO
   } state_t;

   state_t state, state_nxt, seq_state;

   logic [7:0]        type_nxt;
   logic              pop;
   logic              push;
   logic              fifo_empty;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];

   // ------------------------------------------------------------------
   // FIFO status and handshake
   // ------------------------------------------------------------------
   assign fifo_empty   = (fifo_level == '0);
   // Full FIFO refuses the sample even if a pop happens the same cycle, so
   // the source never has to reason about the packet request timing.
   assign sample_ready = (fifo_level != FULL_LEVEL);
   assign push         = sample_valid && sample_ready;

   // ------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------

   // Sequencer state register.
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_ACR;
      end else begin
         // NOTE: all clocked state is updated with <= so every register sees
         // the pre-edge values of its neighbours, independent of block order.
         state <= state_nxt;
      end
   end

   // Next-state and packet selection; frame_start restarts the sequence and,
   // when it coincides with a request, that request is served from S_ACR.
   always_comb begin
      // NOTE: every output of this block is given a default first, so no
      // path leaves a value unassigned and no latch is inferred.
      seq_state = state;
      state_nxt = state;
      type_nxt  = packet_type;
      pop       = 1'b0;

      if (frame_start) begin
         seq_state = S_ACR;
      end
      state_nxt = seq_state;

      if (packet_enable) begin
         case (seq_state)
            S_ACR: begin
               type_nxt  = PT_ACR;
               state_nxt = S_AIF;
            end
            S_AIF: begin
               type_nxt  = PT_AIF;
               state_nxt = (SEND_AVI != 0) ? S_AVI : S_AUDIO;
            end
            S_AVI: begin
               type_nxt  = PT_AVI;
               state_nxt = S_AUDIO;
            end
            S_AUDIO: begin
               if (!fifo_empty) begin
                  type_nxt = PT_AUDIO;
                  pop      = 1'b1;
               end else begin
                  type_nxt = PT_NULL;
               end
            end
            default: begin
               state_nxt = S_ACR;
            end
         endcase
      end
   end

   // Packet type and carried sample, held between requests.
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         packet_type       <= PT_NULL;
         audio_sample_word <= '0;
      end else begin
         packet_type <= type_nxt;
         if (pop) begin
            audio_sample_word <= mem[rd_ptr];
         end
      end
   end

   // ------------------------------------------------------------------
   // Sample FIFO
   // ------------------------------------------------------------------

   // Sample storage; a written entry is readable from the following cycle.
   always_ff @(posedge clk_pixel) begin
      // NOTE: the storage array has no reset; occupancy is tracked by the
      // pointers and level, which are reset, so stale data is never read.
      if (push) begin
         mem[wr_ptr] <= sample_in;
      end
   end

   // Pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // Occupancy: simultaneous push and pop leaves the level unchanged.
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         fifo_level <= '0;
      end else begin
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LEVEL_W'(1);
            2'b01:   fifo_level <= fifo_level - LEVEL_W'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Sticky drop flag; only reset clears it, frame boundaries do not.
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (sample_valid && !sample_ready) begin
         overflow <= 1'b1;
      end
   end

endmodule
